// File: rtl/mux_ctrl_pkg.sv
// mux_ctrl_pkg: shared sizes, FSM states and index helper for the mux select arbiter
package mux_ctrl_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {IDLE, BUSY} state_t;

    // Binary index of a one-hot vector; all-zero maps to 0
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        onehot_to_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (oh[i]) onehot_to_idx = onehot_to_idx | SEL_W'(i);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin pick of the first eligible request at or after ptr
module rr_pick8
    import mux_ctrl_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [NREQ-1:0]  excl,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   low;

    // Rotate so ptr lands at bit 0, isolate the lowest set bit, then rotate the index back
    always_comb begin
        dbl   = {2{req & ~excl}} >> ptr;
        rot   = dbl[NREQ-1:0];
        low   = rot & (~rot + 8'd1);
        found = |rot;
        idx   = onehot_to_idx(low) + ptr;
    end

endmodule

// File: rtl/mux8_sel_arbiter.sv
// mux8_sel_arbiter: round-robin owner of an 8:1 mux select with bounded tenure
module mux8_sel_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  grant,
    output logic             grant_valid,
    output logic [SEL_W-1:0] sel,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic             at_max;
    logic             rel;
    logic             ex_found;
    logic             pl_found;
    logic [SEL_W-1:0] ex_idx;
    logic [SEL_W-1:0] pl_idx;
    logic             found;
    logic [SEL_W-1:0] win;

    // Prefer anyone but the current owner; fall back to the owner only if it is the sole requester
    rr_pick8 u_pick_ex (.req(req), .ptr(ptr), .excl(grant), .found(ex_found), .idx(ex_idx));
    rr_pick8 u_pick_pl (.req(req), .ptr(ptr), .excl('0),    .found(pl_found), .idx(pl_idx));

    // Release conditions for the current owner and the merged winner
    always_comb begin
        at_max = hold_cnt == HOLD_LIM;
        rel    = done | ~req[sel] | at_max;
        found  = ex_found | pl_found;
        win    = ex_found ? ex_idx : pl_idx;
    end

    // FSM with registered grant/sel/timeout; sel keeps its last value when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            sel         <= '0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE || rel) begin
                if (state == BUSY) timeout <= at_max;
                if (found) begin
                    state       <= BUSY;
                    grant       <= NREQ'(1) << win;
                    grant_valid <= 1'b1;
                    sel         <= win;
                    ptr         <= win + 3'd1;
                    hold_cnt    <= 8'd1;
                end else begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    hold_cnt    <= '0;
                end
            end else if (hold_cnt < HOLD_LIM) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux8_sel_arbiter.sv
// tb_mux8_sel_arbiter: randomized and directed checks against a behavioural round-robin model
module tb_mux8_sel_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] sel;
    logic       timeout;

    int vectors = 0;
    int errors = 0;

    int       m_owner = -1;
    int       m_ptr = 0;
    int       m_ten = 0;
    int       m_sel = 0;
    bit       m_to = 0;
    logic [7:0] e_grant;

    always #5 clk = ~clk;

    mux8_sel_arbiter #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_valid(grant_valid), .sel(sel), .timeout(timeout)
    );

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_ten = 0; m_sel = 0; m_to = 0; e_grant = '0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        int w;
        m_to = 0;
        if (m_owner >= 0 && !d && r[m_owner] && m_ten < HM) begin
            m_ten++;
        end else begin
            m_to = (m_owner >= 0) && (m_ten == HM);
            w = -1;
            for (int k = 0; k < 8; k++)
                if (w < 0 && r[(m_ptr + k) % 8] && ((m_ptr + k) % 8) != m_owner) w = (m_ptr + k) % 8;
            if (w < 0 && m_owner >= 0 && r[m_owner]) w = m_owner;
            if (w >= 0) begin
                m_owner = w; m_ptr = (w + 1) % 8; m_ten = 1; m_sel = w;
            end else begin
                m_owner = -1; m_ten = 0;
            end
        end
        e_grant = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    endtask

    task automatic tick(input logic [7:0] r, input logic d);
        @(negedge clk);
        req = r; done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; req = '0; done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        vectors++;
        if ({grant, grant_valid, sel, timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset: got grant=%h gv=%b sel=%0d to=%b want all zero", grant, grant_valid, sel, timeout);
        end
        do_reset();
    endtask

    task automatic test_single_and_handover();
        tick(8'h04, 0);
        vectors++;
        if (grant !== 8'h04 || grant_valid !== 1'b1 || sel !== 3'd2) begin
            errors++;
            $display("FAIL single_grant: got grant=%h gv=%b sel=%0d want grant=04 gv=1 sel=2", grant, grant_valid, sel);
        end
        tick(8'h05, 1);
        vectors++;
        if (grant !== 8'h01 || grant_valid !== 1'b1 || sel !== 3'd0) begin
            errors++;
            $display("FAIL handover: got grant=%h gv=%b sel=%0d want grant=01 gv=1 sel=0", grant, grant_valid, sel);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            tick(8'hFF, 1);
            vectors++;
            if (sel !== 3'(k % 8) || grant !== (8'd1 << (k % 8)) || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL round_robin[%0d]: got sel=%0d grant=%h want sel=%0d", k, sel, grant, k % 8);
            end
        end
    endtask

    task automatic test_timeout_sole();
        int pulses;
        do_reset();
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick(8'h20, 0);
            pulses += int'(timeout);
            vectors++;
            if (grant !== 8'h20 || timeout !== m_to || sel !== 3'd5) begin
                errors++;
                $display("FAIL timeout_sole[%0d]: got grant=%h to=%b sel=%0d want grant=20 to=%b sel=5", k, grant, timeout, sel, m_to);
            end
        end
        vectors++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL timeout_sole_count: got %0d pulses want 2", pulses);
        end
    endtask

    task automatic test_timeout_switch();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(8'h42, 0);
            vectors++;
            if (sel !== ((k < 4) ? 3'd1 : 3'd6) || timeout !== (k == 4)) begin
                errors++;
                $display("FAIL timeout_switch[%0d]: got sel=%0d to=%b want sel=%0d to=%b", k, sel, timeout, (k < 4) ? 1 : 6, k == 4);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(8'h08, 0);
        tick(8'h08, 0);
        vectors++;
        if (grant !== 8'h08) begin
            errors++;
            $display("FAIL async_setup: got grant=%h want 08", grant);
        end
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        vectors++;
        if ({grant, grant_valid, sel, timeout} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got grant=%h gv=%b sel=%0d to=%b want all zero", grant, grant_valid, sel, timeout);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        tick(8'h88, 0);
        vectors++;
        if (sel !== 3'd3 || grant !== 8'h08) begin
            errors++;
            $display("FAIL async_restart: got sel=%0d grant=%h want sel=3 grant=08", sel, grant);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = 8'($urandom) & 8'($urandom);
            tick(r, ($urandom_range(0, 3) == 0));
            vectors++;
            if (grant !== e_grant || grant_valid !== (m_owner >= 0) || timeout !== m_to ||
                (m_owner >= 0 && sel !== 3'(m_sel))) begin
                errors++;
                $display("FAIL random[%0d]: got grant=%h gv=%b sel=%0d to=%b want grant=%h gv=%b sel=%0d to=%b",
                         k, grant, grant_valid, sel, timeout, e_grant, m_owner >= 0, m_sel, m_to);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_and_handover();
        test_round_robin();
        test_timeout_sole();
        test_timeout_switch();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
